// File: rtl/dp_share_arbiter.sv
// dp_share_arbiter
// Round-robin arbiter sharing one ALU/register-file datapath among N
// sequencing controllers. A controller keeps the grant for a whole job. A
// watchdog reclaims the datapath from a grantee that never completes.
//
// Ports
//   Clk, Rst           clock; synchronous active-high reset
//   Req[N]             per-controller request
//   ReqDone[N]         per-controller job-complete strobe (grantee only)
//   ReqOpcode[N*OPW]   per-controller opcode, slice [i*OPW +: OPW]
//   ReqR1/ReqR2[N*2]   per-controller register selects, slice [i*2 +: 2]
//   zero_flag          datapath zero flag
//   Grant[N]           registered one-hot grant, zero when nothing is held
//   GrantId            index of the current or most recent grantee
//   opcode, R1, R2     datapath controls from the grantee, NOP when not busy
//   ZeroOut[N]         zero_flag routed to the grantee only
//   Abort[N]           one-cycle pulse to a grantee reclaimed by the watchdog
//   Busy               high while a grant is held
//   TimeoutErr         sticky watchdog-abort flag, cleared only by Rst
module dp_share_arbiter #(
    parameter int N       = 4,
    parameter int OPW     = 3,
    parameter int TIMEOUT = 64
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [N-1:0]         Req,
    input  logic [N-1:0]         ReqDone,
    input  logic [N*OPW-1:0]     ReqOpcode,
    input  logic [N*2-1:0]       ReqR1,
    input  logic [N*2-1:0]       ReqR2,
    input  logic                 zero_flag,
    output logic [N-1:0]         Grant,
    output logic [$clog2(N)-1:0] GrantId,
    output logic [OPW-1:0]       opcode,
    output logic [1:0]           R1,
    output logic [1:0]           R2,
    output logic [N-1:0]         ZeroOut,
    output logic [N-1:0]         Abort,
    output logic                 Busy,
    output logic                 TimeoutErr
);
    localparam int IDW = $clog2(N);
    localparam int WDW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t         state_r, state_n;
    logic [N-1:0]   grant_r, grant_n;
    logic [IDW-1:0] grant_id_r, grant_id_n;
    logic [IDW-1:0] ptr_r, ptr_n;
    logic [WDW-1:0] wdog_r, wdog_n;
    logic [N-1:0]   abort_r, abort_n;
    logic           terr_r, terr_n;
    logic           win_found_s;
    logic [IDW-1:0] win_id_s;

    // Round-robin search: first requester after the pointer, wrapping.
    always_comb begin
        win_found_s = 1'b0;
        win_id_s    = '0;
        for (int k = 1; k <= N; k++) begin
            logic [IDW-1:0] cand;
            logic           hit;
            cand        = IDW'((int'(ptr_r) + k) % N);
            hit         = Req[cand] & ~win_found_s;
            win_id_s    = hit ? cand : win_id_s;
            win_found_s = win_found_s | Req[cand];
        end
    end

    // Next-state and next-output logic for the grant FSM.
    always_comb begin
        state_n    = state_r;
        grant_n    = grant_r;
        grant_id_n = grant_id_r;
        ptr_n      = ptr_r;
        wdog_n     = wdog_r;
        abort_n    = '0;
        terr_n     = terr_r;
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_n    = ST_BUSY;
                    grant_n    = N'(1) << win_id_s;
                    grant_id_n = win_id_s;
                    ptr_n      = win_id_s;
                    wdog_n     = '0;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // A normal release outranks watchdog expiry in the same cycle.
                if (ReqDone[grant_id_r] || !Req[grant_id_r]) begin
                    state_n = ST_GAP;
                    grant_n = '0;
                end else if (wdog_r == WDW'(TIMEOUT - 1)) begin
                    state_n = ST_GAP;
                    grant_n = '0;
                    abort_n = grant_r;
                    terr_n  = 1'b1;
                end else begin
                    wdog_n = wdog_r + WDW'(1);
                end
            end
            ST_GAP: begin
                // Datapath turnaround; never grants here.
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
                grant_n = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r    <= ST_IDLE;
            grant_r    <= '0;
            grant_id_r <= IDW'(N - 1);
            ptr_r      <= IDW'(N - 1);
            wdog_r     <= '0;
            abort_r    <= '0;
            terr_r     <= 1'b0;
        end else begin
            state_r    <= state_n;
            grant_r    <= grant_n;
            grant_id_r <= grant_id_n;
            ptr_r      <= ptr_n;
            wdog_r     <= wdog_n;
            abort_r    <= abort_n;
            terr_r     <= terr_n;
        end
    end

    // Datapath mux driven from the registered grant; NOP when idle.
    always_comb begin
        if (state_r == ST_BUSY) begin
            opcode = ReqOpcode[grant_id_r*OPW +: OPW];
            R1     = ReqR1[grant_id_r*2 +: 2];
            R2     = ReqR2[grant_id_r*2 +: 2];
        end else begin
            opcode = '0;
            R1     = 2'b00;
            R2     = 2'b00;
        end
    end

    assign Grant      = grant_r;
    assign GrantId    = grant_id_r;
    assign ZeroOut    = {N{zero_flag}} & grant_r;
    assign Abort      = abort_r;
    assign Busy       = (state_r == ST_BUSY);
    assign TimeoutErr = terr_r;
endmodule

// File: tb/tb_dp_share_arbiter.sv
// Self-checking bench for dp_share_arbiter (N=4, OPW=3, TIMEOUT=8).
module tb_dp_share_arbiter;
    localparam int N  = 4;
    localparam int TO = 8;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [3:0]  Req = 4'b0000, ReqDone = 4'b0000;
    logic [11:0] ReqOpcode = 12'h000;
    logic [7:0]  ReqR1 = 8'h00, ReqR2 = 8'h00;
    logic        zero_flag = 1'b0;
    logic [3:0]  Grant, ZeroOut, Abort;
    logic [1:0]  GrantId, R1, R2;
    logic [2:0]  opcode;
    logic        Busy, TimeoutErr;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: who holds the datapath, how long it has held it,
    // and how many turnaround cycles remain before arbitration resumes.
    int         m_hold = -1;
    int         m_last = N - 1;
    int         m_used = 0;
    int         m_cool = 0;
    logic [3:0] m_abort = 4'b0000;
    logic       m_terr = 1'b0;

    dp_share_arbiter #(.N(4), .OPW(3), .TIMEOUT(TO)) dut (
        .Clk(Clk), .Rst(Rst), .Req(Req), .ReqDone(ReqDone),
        .ReqOpcode(ReqOpcode), .ReqR1(ReqR1), .ReqR2(ReqR2),
        .zero_flag(zero_flag), .Grant(Grant), .GrantId(GrantId),
        .opcode(opcode), .R1(R1), .R2(R2), .ZeroOut(ZeroOut),
        .Abort(Abort), .Busy(Busy), .TimeoutErr(TimeoutErr)
    );

    always #5 Clk = ~Clk;

    task automatic model_step();
        if (Rst) begin
            m_hold = -1; m_last = N - 1; m_used = 0; m_cool = 0;
            m_abort = 4'b0000; m_terr = 1'b0;
        end else begin
            m_abort = 4'b0000;
            if (m_hold >= 0) begin
                if (ReqDone[m_hold] || !Req[m_hold]) begin
                    m_hold = -1; m_cool = 1;
                end else if (m_used == TO) begin
                    m_abort[m_hold] = 1'b1; m_terr = 1'b1;
                    m_hold = -1; m_cool = 1;
                end else begin
                    m_used++;
                end
            end else if (m_cool > 0) begin
                m_cool--;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_last + k) % N;
                    if (Req[c]) begin
                        m_hold = c; m_last = c; m_used = 1;
                        break;
                    end
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        Req = 4'b0000; ReqDone = 4'b0000; ReqOpcode = 12'h000;
        ReqR1 = 8'h00; ReqR2 = 8'h00; zero_flag = 1'b0;
    endtask

    task automatic do_reset();
        Rst = 1'b1; clear_inputs(); cyc(); Rst = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        Req = 4'($urandom); ReqDone = 4'($urandom); ReqOpcode = 12'($urandom);
        ReqR1 = 8'($urandom); ReqR2 = 8'($urandom); zero_flag = 1'b1;
        cyc(); cyc();
        n_cmp++; if (Grant !== 4'b0000) begin n_bad++; $display("FAIL reset_grant: got %b want 0000", Grant); end
        n_cmp++; if (opcode !== 3'b000) begin n_bad++; $display("FAIL reset_opcode: got %b want 000", opcode); end
        n_cmp++; if ({R1, R2} !== 4'b0000) begin n_bad++; $display("FAIL reset_r1r2: got %b want 0000", {R1, R2}); end
        n_cmp++; if (Abort !== 4'b0000) begin n_bad++; $display("FAIL reset_abort: got %b want 0000", Abort); end
        n_cmp++; if (TimeoutErr !== 1'b0) begin n_bad++; $display("FAIL reset_terr: got %b want 0", TimeoutErr); end
        n_cmp++; if (GrantId !== 2'd3) begin n_bad++; $display("FAIL reset_grantid: got %0d want 3", GrantId); end
        n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", Busy); end
        Rst = 1'b0; clear_inputs(); cyc();
    endtask

    task automatic test_single();
        do_reset();
        ReqOpcode = 12'($urandom); ReqR1 = 8'($urandom); ReqR2 = 8'($urandom);
        ReqOpcode[8:6] = 3'b101; ReqR1[5:4] = 2'b01; ReqR2[5:4] = 2'b10;
        Req = 4'b0100; zero_flag = 1'b1;
        cyc();
        n_cmp++; if (Grant !== 4'b0100) begin n_bad++; $display("FAIL single_grant: got %b want 0100", Grant); end
        n_cmp++; if (GrantId !== 2'd2) begin n_bad++; $display("FAIL single_grantid: got %0d want 2", GrantId); end
        n_cmp++; if ({opcode, R1, R2} !== 7'b101_01_10) begin n_bad++; $display("FAIL single_mux: got %b want 1010110", {opcode, R1, R2}); end
        n_cmp++; if (ZeroOut !== 4'b0100) begin n_bad++; $display("FAIL single_zeroout: got %b want 0100", ZeroOut); end
        cyc();
        ReqDone = 4'b0100;
        cyc();
        ReqDone = 4'b0000; Req = 4'b0000;
        n_cmp++; if ({Grant, Busy, opcode} !== 8'b0) begin n_bad++; $display("FAIL single_gap: got %b want 0", {Grant, Busy, opcode}); end
        n_cmp++; if (ZeroOut !== 4'b0000) begin n_bad++; $display("FAIL single_gap_zero: got %b want 0000", ZeroOut); end
        n_cmp++; if (Abort !== 4'b0000) begin n_bad++; $display("FAIL single_gap_abort: got %b want 0000", Abort); end
        cyc();
        n_cmp++; if ({Grant, Busy} !== 5'b0) begin n_bad++; $display("FAIL single_idle: got %b want 0", {Grant, Busy}); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        Req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int idle;
            idle = 0;
            while (Grant === 4'b0000 && idle < 20) begin idle++; cyc(); end
            n_cmp++; if (Grant !== (4'b0001 << (k % 4))) begin n_bad++; $display("FAIL simul_order%0d: got %b want %b", k, Grant, 4'b0001 << (k % 4)); end
            if (k > 0) begin
                n_cmp++; if (idle != 2) begin n_bad++; $display("FAIL simul_gap%0d: got %0d idle want 2", k, idle); end
            end
            cyc(); cyc();
            ReqDone = Grant;
            cyc();
            ReqDone = 4'b0000;
        end
        Req = 4'b0000;
    endtask

    task automatic test_fairness();
        do_reset();
        Req = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            int idle;
            idle = 0;
            while (Grant === 4'b0000 && idle < 20) begin idle++; cyc(); end
            n_cmp++; if (Grant !== (4'b0001 << (k % 2))) begin n_bad++; $display("FAIL fair_order%0d: got %b want %b", k, Grant, 4'b0001 << (k % 2)); end
            cyc();
            ReqDone = Grant;
            cyc();
            ReqDone = 4'b0000;
        end
        Req = 4'b0000;
    endtask

    task automatic test_watchdog();
        int n;
        do_reset();
        Req = 4'b1000;
        cyc();
        Req = 4'b1010;
        n = 0;
        while (Busy === 1'b1 && n < 40) begin n++; cyc(); end
        n_cmp++; if (n != TO) begin n_bad++; $display("FAIL wdog_busy_len: got %0d want %0d", n, TO); end
        n_cmp++; if (Abort !== 4'b1000) begin n_bad++; $display("FAIL wdog_abort: got %b want 1000", Abort); end
        n_cmp++; if (TimeoutErr !== 1'b1) begin n_bad++; $display("FAIL wdog_terr: got %b want 1", TimeoutErr); end
        cyc();
        n_cmp++; if ({Abort, TimeoutErr} !== 5'b00001) begin n_bad++; $display("FAIL wdog_after: got %b want 00001", {Abort, TimeoutErr}); end
        cyc();
        n_cmp++; if (Grant !== 4'b0010) begin n_bad++; $display("FAIL wdog_next: got %b want 0010", Grant); end
        Req = 4'b1000;
        cyc(); cyc(); cyc();
        n_cmp++; if (Grant !== 4'b1000) begin n_bad++; $display("FAIL wdog_regrant: got %b want 1000", Grant); end
        for (int i = 0; i < TO - 1; i++) cyc();
        n_cmp++; if (Busy !== 1'b1) begin n_bad++; $display("FAIL wdog_8th_busy: got %b want 1", Busy); end
        ReqDone = 4'b1000;
        cyc();
        ReqDone = 4'b0000; Req = 4'b0000;
        n_cmp++; if ({Grant, Abort} !== 8'b0) begin n_bad++; $display("FAIL wdog_done_wins: got %b want 0", {Grant, Abort}); end
        n_cmp++; if (TimeoutErr !== 1'b1) begin n_bad++; $display("FAIL wdog_sticky: got %b want 1", TimeoutErr); end
        cyc();
    endtask

    task automatic test_reset_mid();
        do_reset();
        ReqOpcode = 12'hFFF;
        Req = 4'b0100;
        cyc(); cyc(); cyc();
        Rst = 1'b1;
        cyc();
        Rst = 1'b0;
        n_cmp++; if ({Grant, Busy, opcode} !== 8'b0) begin n_bad++; $display("FAIL rstmid_clear: got %b want 0", {Grant, Busy, opcode}); end
        n_cmp++; if (GrantId !== 2'd3) begin n_bad++; $display("FAIL rstmid_id: got %0d want 3", GrantId); end
        Req = 4'b1101;
        cyc();
        n_cmp++; if (Grant !== 4'b0001) begin n_bad++; $display("FAIL rstmid_favour0: got %b want 0001", Grant); end
        clear_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int t = 0; t < 600; t++) begin
            logic [3:0] eg;
            logic [2:0] eop;
            logic [1:0] er1, er2;
            for (int i = 0; i < 4; i++) if ($urandom_range(0, 7) == 0) Req[i] = ~Req[i];
            ReqDone   = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
            ReqOpcode = 12'($urandom); ReqR1 = 8'($urandom); ReqR2 = 8'($urandom);
            zero_flag = 1'($urandom);
            Rst       = ($urandom_range(0, 79) == 0);
            cyc();
            if (m_hold >= 0) begin
                eg = 4'b0001 << m_hold;
                eop = ReqOpcode[m_hold*3 +: 3]; er1 = ReqR1[m_hold*2 +: 2]; er2 = ReqR2[m_hold*2 +: 2];
            end else begin
                eg = 4'b0000; eop = 3'b000; er1 = 2'b00; er2 = 2'b00;
            end
            n_cmp++; if (Grant !== eg) begin n_bad++; $display("FAIL rnd_grant t=%0d: got %b want %b", t, Grant, eg); end
            n_cmp++; if (GrantId !== 2'(m_last)) begin n_bad++; $display("FAIL rnd_grantid t=%0d: got %0d want %0d", t, GrantId, m_last); end
            n_cmp++; if (Busy !== (m_hold >= 0)) begin n_bad++; $display("FAIL rnd_busy t=%0d: got %b want %b", t, Busy, m_hold >= 0); end
            n_cmp++; if ({opcode, R1, R2} !== {eop, er1, er2}) begin n_bad++; $display("FAIL rnd_mux t=%0d: got %b want %b", t, {opcode, R1, R2}, {eop, er1, er2}); end
            n_cmp++; if (ZeroOut !== (zero_flag ? eg : 4'b0000)) begin n_bad++; $display("FAIL rnd_zeroout t=%0d: got %b want %b", t, ZeroOut, zero_flag ? eg : 4'b0000); end
            n_cmp++; if (Abort !== m_abort) begin n_bad++; $display("FAIL rnd_abort t=%0d: got %b want %b", t, Abort, m_abort); end
            n_cmp++; if (TimeoutErr !== m_terr) begin n_bad++; $display("FAIL rnd_terr t=%0d: got %b want %b", t, TimeoutErr, m_terr); end
        end
        Rst = 1'b0; clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_watchdog();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dp_share_arbiter.md
# dp_share_arbiter

Round-robin arbiter that shares the single ALU/register-file datapath among up to N sequencing controllers. Each controller requests the datapath and holds a grant for a whole job (a multi-cycle opcode/register-select sequence). The arbiter muxes the granted controller's opcode and R1/R2 selects onto the datapath and routes zero_flag back to that controller only. A watchdog reclaims the datapath from a controller that never signals completion. It sits between the controller FSMs and the datapath.

## Interface
- N, 4: number of requesting controllers (N >= 2).
- OPW, 3: opcode width.
- TIMEOUT, 64: maximum BUSY cycles per grant (>= 2).
- Clk  in  1  clock; all state changes on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- Req  in  N  request; bit i belongs to controller i.
- ReqDone  in  N  job-complete strobe from controller i; honoured only from the grantee.
- ReqOpcode  in  N*OPW  opcode from controller i at [i*OPW +: OPW].
- ReqR1, ReqR2  in  N*2 each  register selects from controller i at [i*2 +: 2].
- zero_flag  in  1  datapath zero flag.
- Grant  out  N  one-hot grant (registered); all zeros when no grant is held.
- GrantId  out  $clog2(N)  index of the current or last grantee.
- opcode  out  OPW  opcode driven to the datapath.
- R1, R2  out  2 each  register selects driven to the datapath.
- ZeroOut  out  N  ZeroOut[i] = zero_flag & Grant[i].
- Abort  out  N  one-cycle pulse to a grantee whose grant was revoked by the watchdog.
- Busy  out  1  high in the BUSY state.
- TimeoutErr  out  1  sticky; set on any watchdog abort and cleared only by Rst.

## Operation
- States: IDLE, BUSY, GAP. Rst puts the block in IDLE.
- Reset values: Grant=0, GrantId=N-1, Abort=0, TimeoutErr=0, Busy=0, rr pointer=N-1, watchdog=0.
- IDLE, no Req bit set: stay in IDLE.
- IDLE, any Req bit set:
  - Winner is the first set bit searching from index (ptr+1) mod N upward, wrapping.
  - Next edge: Grant = onehot(winner), GrantId = winner, ptr = winner, watchdog = 0, state = BUSY.
- BUSY, with g = GrantId, evaluated in this priority order:
  - ReqDone[g]=1 or Req[g]=0: go to GAP with Grant=0. This is a normal release; no Abort.
  - watchdog == TIMEOUT-1: go to GAP with Grant=0, pulse Abort[g] for the first GAP cycle, set TimeoutErr.
  - Otherwise: watchdog increments by 1.
- GAP lasts exactly one cycle, then goes to IDLE. The gap is the datapath turnaround cycle; no new grant is issued in GAP.
- Datapath outputs are combinational from the registered grant:
  - While Busy: opcode = ReqOpcode[g], R1 = ReqR1[g], R2 = ReqR2[g].
  - Otherwise: opcode=0 (NOP), R1=0, R2=0.
- ReqDone and Req from non-grantees have no effect in BUSY. Requests wait; there is no preemption except by the watchdog.
- The pointer rotates on every grant, so the most recently served controller has the lowest priority in the next arbitration.

## Timing
- Req sampled in IDLE at edge t gives Grant at edge t+1. The minimum request-to-grant latency is 1 cycle.
- A grant holds for at most TIMEOUT BUSY cycles.
- ReqDone sampled at edge t gives Grant=0 after edge t+1 (GAP). The earliest next grant is after edge t+3.
- Back-to-back jobs from different controllers are separated by one GAP plus one IDLE cycle. Throughput overhead is 2 cycles per handover.
- If ReqDone and the watchdog expiry occur in the same cycle, ReqDone wins: no Abort, TimeoutErr unchanged.
- If the grantee re-requests during GAP or IDLE, it competes normally. The rotated pointer puts other pending requesters first.
- If Rst is asserted mid-BUSY, all outputs return to reset values on the next edge. A pending Abort is discarded.
- Worst-case wait for a requester: (N-1)*(TIMEOUT+2) cycles.

## Test plan
- Reset: hold Rst 2 cycles with random inputs -> Grant=0, opcode=0, R1=R2=0, Abort=0, TimeoutErr=0, GrantId=N-1.
- Single request: Req=0100, ReqOpcode[2]=3'b101, ReqR1[2]=2'b01 -> Grant=0100 one cycle later and opcode=101, R1=01. ZeroOut=0100 when zero_flag=1. ReqDone[2] -> Grant=0 for one GAP cycle, then IDLE.
- Simultaneous: Req=1111 held, each job 3 cycles, from reset -> grants in order 0,1,2,3,0, each separated by 2 idle cycles.
- Fairness: Req[0] and Req[1] held continuously, ReqDone after 2 cycles -> grants alternate 0,1,0,1. Controllers 2 and 3 are never granted.
- Watchdog: TIMEOUT=8, Req[3] held with no ReqDone -> exactly 8 BUSY cycles, then Abort=1000 for 1 cycle and TimeoutErr=1 stays set. A pending Req[1] is granted 2 cycles later. Repeat with ReqDone[3] in the 8th cycle -> no Abort.
- Reset mid-grant: Rst in the 3rd BUSY cycle -> next edge shows Grant=0, Busy=0, opcode=0. The next grant after release favours controller 0.
